// File: rtl/combination_lock_pkg.sv
// Shared types for the combination-lock sweeper: digit width, digit type
// and the sweeper state encoding.
package combination_lock_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle timer for the dial sweeper. Loaded with SETTLE_CYCLES-1 when a new
// guess is presented, counts down while the sweeper sits in DRIVE and
// reports expiry when it reaches zero.
module sweep_settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Down-counter: reload on every new guess, stop at zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_run && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/combination_dial_sweeper.sv
// Combination dial sweeper. Walks each digit position from 0 up to DIGIT_MAX,
// freezing a position as soon as its comparator flags a match, and reports
// the recovered combination with done, or fail if a position never matches.
// Handshake: start/abort are single-cycle pulses sampled on the rising edge;
// start is honoured only in IDLE/DONE/FAIL, abort in every state and wins
// over a simultaneous start. busy is high exactly in DRIVE and CHECK.
// Optional macro SWEEP_ATTEMPT_CNT_EN adds a saturating 16-bit attempt_count.
module combination_dial_sweeper
    import combination_lock_pkg::*;
#(
    parameter int  NUM_DIGITS    = 4,
    parameter int  DIGIT_MAX     = 9,
    parameter int  SETTLE_CYCLES = 1,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_DIGITS-1:0]         digit_found_flag,
    output logic [DIGIT_W*NUM_DIGITS-1:0] guess_bus,
    output logic [IDX_W-1:0]              digit_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          fail,
    output sweep_state_t                  dbg_state
`ifdef SWEEP_ATTEMPT_CNT_EN
    ,
    output logic [15:0]                   attempt_count
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam digit_t           GUESS_MAX = digit_t'(DIGIT_MAX);

    sweep_state_t                  r_state;
    sweep_state_t                  w_next_state;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_guess_bus;
    logic [IDX_W-1:0]              r_digit_idx;
    digit_t                        w_cur_guess;
    logic                          w_cur_flag;
    logic                          w_clear;
    logic                          w_inc_guess;
    logic                          w_advance;
    logic                          w_timer_load;
    logic                          w_timer_run;
    logic                          w_expired;

    // Select the guess and the found flag of the position being swept
    always_comb begin
        w_cur_guess = '0;
        w_cur_flag  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_cur_guess = r_guess_bus[i*DIGIT_W +: DIGIT_W];
                w_cur_flag  = digit_found_flag[i];
            end
        end
    end

    assign w_timer_run = (r_state == ST_DRIVE);

    sweep_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_timer_load),
        .i_run    (w_timer_run),
        .o_expired(w_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_inc_guess  = 1'b0;
        w_advance    = 1'b0;
        w_timer_load = 1'b0;
        if (abort) begin
            w_next_state = ST_IDLE;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        w_next_state = ST_DRIVE;
                        w_clear      = 1'b1;
                        w_timer_load = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (w_expired) begin
                        w_next_state = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_cur_flag) begin
                        if (r_digit_idx == LAST_IDX) begin
                            w_next_state = ST_DONE;
                        end else begin
                            // Next slice is still 0 since it was never visited
                            w_advance    = 1'b1;
                            w_timer_load = 1'b1;
                            w_next_state = ST_DRIVE;
                        end
                    end else if (w_cur_guess < GUESS_MAX) begin
                        w_inc_guess  = 1'b1;
                        w_timer_load = 1'b1;
                        w_next_state = ST_DRIVE;
                    end else begin
                        w_next_state = ST_FAIL;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Guess slices and position index
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_guess_bus <= '0;
            r_digit_idx <= '0;
        end else if (w_clear) begin
            r_guess_bus <= '0;
            r_digit_idx <= '0;
        end else if (w_inc_guess) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_digit_idx == IDX_W'(i)) begin
                    r_guess_bus[i*DIGIT_W +: DIGIT_W] <= w_cur_guess + 1'b1;
                end
            end
        end else if (w_advance) begin
            r_digit_idx <= r_digit_idx + 1'b1;
        end
    end

`ifdef SWEEP_ATTEMPT_CNT_EN
    logic [15:0] r_attempt_count;

    // Count CHECK cycles of the current sweep, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_attempt_count <= '0;
        end else if (w_clear) begin
            r_attempt_count <= '0;
        end else if ((r_state == ST_CHECK) && (r_attempt_count != 16'hFFFF)) begin
            r_attempt_count <= r_attempt_count + 16'd1;
        end
    end

    assign attempt_count = r_attempt_count;
`endif

    assign guess_bus = r_guess_bus;
    assign digit_idx = r_digit_idx;
    assign busy      = (r_state == ST_DRIVE) || (r_state == ST_CHECK);
    assign done      = (r_state == ST_DONE);
    assign fail      = (r_state == ST_FAIL);
    assign dbg_state = r_state;

endmodule
